// File: rtl/err_metric_acc.sv
// Error-metric collector for the approximate multiplier: accumulates ED sum, max ED
// and erroneous-product count over a programmed window, then pulses done.
module err_metric_acc #(
   parameter int PW = 16,
   parameter int NW = 16,
   parameter int SW = PW + NW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] n_samples,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] prod_apx,
   input  logic [PW-1:0] prod_exact,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sum_ed,
   output logic [PW-1:0] max_ed,
   output logic [NW-1:0] err_cnt,
   output logic [NW-1:0] acc_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [NW-1:0] n_lat;
   logic          drain_cnt;
   logic          hs;
   logic          start_ok;

   logic          vld_p1, vld_p2;
   logic [PW-1:0] ed_p1, ed_p2;
   logic          ne_p1, ne_p2;

   // Larger minus smaller keeps the unsigned difference from ever wrapping.
   function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
      abs_diff = (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [PW-1:0] max_of(input logic [PW-1:0] a, input logic [PW-1:0] b);
      max_of = (a >= b) ? a : b;
   endfunction

   assign hs       = in_valid & in_ready;
   assign start_ok = (state == IDLE) & start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_lat     <= '0;
         drain_cnt <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         acc_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n_lat   <= n_samples;
                  acc_cnt <= '0;
                  busy    <= 1'b1;
                  if (n_samples == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= RUN;
                     in_ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  acc_cnt <= acc_cnt + NW'(1);
                  if (acc_cnt == n_lat - NW'(1)) begin
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     drain_cnt <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // Two cycles let the last beat pass through both pipeline stages.
               if (drain_cnt) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1/2 valids
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (start_ok) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= hs;
         vld_p2 <= vld_p1;
      end
   end

   // Stage 1: error distance and mismatch flag
   always_ff @(posedge clk) begin
      if (hs) begin
         ed_p1 <= abs_diff(prod_apx, prod_exact);
         ne_p1 <= (prod_apx != prod_exact);
      end
   end

   // Stage 2: hand the beat to the accumulators
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         ed_p2 <= ed_p1;
         ne_p2 <= ne_p1;
      end
   end

   // Accumulate; SW = PW + NW bits cannot overflow for any window length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ed  <= '0;
         max_ed  <= '0;
         err_cnt <= '0;
      end else if (start_ok) begin
         sum_ed  <= '0;
         max_ed  <= '0;
         err_cnt <= '0;
      end else if (vld_p2) begin
         sum_ed  <= sum_ed + SW'(ed_p2);
         max_ed  <= max_of(max_ed, ed_p2);
         err_cnt <= err_cnt + NW'(ne_p2);
      end
   end

endmodule
